// File: rtl/pc_sequencer_if.sv
// Fetch-path bundle between the program-counter sequencer, the core's control
// decode and the instruction memory port.
interface pc_sequencer_if;
  logic [31:0] PC_4;
  logic [31:0] PC_Imm;
  logic [31:0] JALR_Target;
  logic        Branch_Taken;
  logic        Jump;
  logic        Jalr;
  logic        Hold;
  logic        IMem_Ack;
  logic        Retire;
  logic [31:0] PC;
  logic        IMem_Req;
  logic [31:0] IMem_Addr;
  logic        Instr_Valid;
  logic        Trap;
  logic [31:0] Trap_PC;
  logic [31:0] Trap_Tval;
  logic [31:0] Instret;

  // Core/memory side: drives control and handshake inputs, observes PC state.
  modport master (
    output PC_4, PC_Imm, JALR_Target, Branch_Taken, Jump, Jalr, Hold,
           IMem_Ack, Retire,
    input  PC, IMem_Req, IMem_Addr, Instr_Valid, Trap, Trap_PC, Trap_Tval,
           Instret
  );

  // Sequencer side.
  modport slave (
    input  PC_4, PC_Imm, JALR_Target, Branch_Taken, Jump, Jalr, Hold,
           IMem_Ack, Retire,
    output PC, IMem_Req, IMem_Addr, Instr_Valid, Trap, Trap_PC, Trap_Tval,
           Instret
  );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: owns the architectural PC, runs the IDLE/FETCH/EXEC
// fetch handshake, selects the next PC, traps misaligned targets, counts retires.
module pc_sequencer #(
  parameter logic [31:0] RESET_VEC = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC  = 32'h0000_0100
) (
  input logic            CLK,
  input logic            RSTN,
  pc_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] pc_q;
  logic [31:0] addr_q;
  logic        req_q;
  logic        valid_q;
  logic        trap_q;
  logic [31:0] trap_pc_q;
  logic [31:0] trap_tval_q;
  logic [31:0] instret_q;

  logic [31:0] target;
  logic        ctrl_sel;
  logic        misaligned;
  logic [31:0] next_pc;

  // JALR always lands on an even address, so the ALU's bit 0 is dropped.
  logic unused_jalr_lsb;
  assign unused_jalr_lsb = bus.JALR_Target[0];

  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path can
    // leave it holding its old value and a latch is never inferred.
    target   = bus.PC_4;
    ctrl_sel = 1'b0;
    if (bus.Jalr) begin
      target   = {bus.JALR_Target[31:1], 1'b0};
      ctrl_sel = 1'b1;
    end else if (bus.Jump) begin
      target   = bus.PC_Imm;
      ctrl_sel = 1'b1;
    end else if (bus.Branch_Taken) begin
      target   = bus.PC_Imm;
      ctrl_sel = 1'b1;
    end
    // The sequential PC_4 path is trusted; only redirects are alignment-checked.
    misaligned = ctrl_sel && (target[1:0] != 2'b00);
    next_pc    = misaligned ? TRAP_VEC : target;
  end

  // NOTE: all architectural state is reset here; there is no storage array,
  // so every flop takes a defined value while RSTN is low.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state       <= IDLE;
      pc_q        <= RESET_VEC;
      addr_q      <= RESET_VEC;
      req_q       <= 1'b0;
      valid_q     <= 1'b0;
      trap_q      <= 1'b0;
      trap_pc_q   <= 32'h0;
      trap_tval_q <= 32'h0;
      instret_q   <= 32'h0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge
      // values, independent of statement order within this block.
      trap_q <= 1'b0;
      case (state)
        IDLE: begin
          if (!bus.Hold) begin
            state  <= FETCH;
            req_q  <= 1'b1;
            addr_q <= pc_q;
          end
        end
        FETCH: begin
          // Hold is not sampled: an outstanding request must complete.
          if (bus.IMem_Ack) begin
            state   <= EXEC;
            req_q   <= 1'b0;
            valid_q <= 1'b1;
          end
        end
        EXEC: begin
          if (bus.Retire) begin
            pc_q    <= next_pc;
            addr_q  <= next_pc;
            valid_q <= 1'b0;
            if (misaligned) begin
              trap_q      <= 1'b1;
              trap_pc_q   <= pc_q;
              trap_tval_q <= target;
            end else begin
              instret_q <= instret_q + 32'd1;
            end
            if (bus.Hold) begin
              state <= IDLE;
              req_q <= 1'b0;
            end else begin
              state <= FETCH;
              req_q <= 1'b1;
            end
          end
        end
        default: begin
          state   <= IDLE;
          req_q   <= 1'b0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.PC          = pc_q;
  assign bus.IMem_Req    = req_q;
  assign bus.IMem_Addr   = addr_q;
  assign bus.Instr_Valid = valid_q;
  assign bus.Trap        = trap_q;
  assign bus.Trap_PC     = trap_pc_q;
  assign bus.Trap_Tval   = trap_tval_q;
  assign bus.Instret     = instret_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: stimulus queues expected fetches and traps,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_pc_sequencer;

  logic CLK  = 1'b0;
  logic RSTN = 1'b0;
  always #5 CLK = ~CLK;

  pc_sequencer_if bus ();

  pc_sequencer #(
    .RESET_VEC(32'h0000_0000),
    .TRAP_VEC (32'h0000_0100)
  ) dut (
    .CLK (CLK),
    .RSTN(RSTN),
    .bus (bus)
  );

  // Model of the external PC incrementer.
  assign bus.PC_4 = bus.PC + 32'd4;

  typedef struct {
    logic [31:0] addr;
    bit          chk_gap;
  } fetch_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] trap_pc;
    logic [31:0] tval;
    logic [31:0] instret;
  } trap_t;

  fetch_t fetch_q[$];
  trap_t  trap_q[$];

  int passed = 0;
  int total  = 0;
  int cyc    = 0;
  int last_hs = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic void exp_fetch(input logic [31:0] addr, input bit gap);
    fetch_q.push_back('{addr, gap});
  endfunction

  always @(posedge CLK) cyc++;

  // Monitor: every accepted fetch and every trap pulse is matched against the queues.
  always @(negedge CLK) begin : monitor
    fetch_t f;
    trap_t  t;
    if (RSTN && bus.IMem_Req && bus.IMem_Ack) begin
      if (fetch_q.size() == 0) begin
        check("fetch_queue_depth", 32'(fetch_q.size()), 32'd1);
      end else begin
        f = fetch_q.pop_front();
        check("fetch_addr", bus.IMem_Addr, f.addr);
        if (f.chk_gap) check("fetch_gap_cycles", 32'(cyc - last_hs), 32'd2);
      end
      last_hs = cyc;
    end
    if (RSTN && bus.Trap) begin
      if (trap_q.size() == 0) begin
        check("trap_queue_depth", 32'(trap_q.size()), 32'd1);
      end else begin
        t = trap_q.pop_front();
        check("trap_new_pc",  bus.PC,        t.pc);
        check("trap_pc",      bus.Trap_PC,   t.trap_pc);
        check("trap_tval",    bus.Trap_Tval, t.tval);
        check("trap_instret", bus.Instret,   t.instret);
      end
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_valid();
    int n = 0;
    @(negedge CLK);
    while (!bus.Instr_Valid && n < 20) begin
      @(negedge CLK);
      n++;
    end
    if (!bus.Instr_Valid) check("instr_valid_timeout", {31'h0, bus.Instr_Valid}, 32'd1);
  endtask

  // Retire in the first cycle the instruction is valid, with the given controls.
  task automatic do_retire(input logic br, input logic jmp, input logic jr,
                           input logic [31:0] imm, input logic [31:0] jt);
    wait_valid();
    bus.Branch_Taken = br;
    bus.Jump         = jmp;
    bus.Jalr         = jr;
    bus.PC_Imm       = imm;
    bus.JALR_Target  = jt;
    bus.Retire       = 1'b1;
    step();
    bus.Retire       = 1'b0;
    bus.Branch_Taken = 1'b0;
    bus.Jump         = 1'b0;
    bus.Jalr         = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_pc"},        bus.PC,          32'h0);
    check({tag, "_req"},       {31'h0, bus.IMem_Req},    32'h0);
    check({tag, "_addr"},      bus.IMem_Addr,   32'h0);
    check({tag, "_valid"},     {31'h0, bus.Instr_Valid}, 32'h0);
    check({tag, "_trap"},      {31'h0, bus.Trap},        32'h0);
    check({tag, "_trap_pc"},   bus.Trap_PC,     32'h0);
    check({tag, "_trap_tval"}, bus.Trap_Tval,   32'h0);
    check({tag, "_instret"},   bus.Instret,     32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    bus.Hold         = 1'b0;
    bus.IMem_Ack     = 1'b1;
    bus.Retire       = 1'b0;
    bus.Branch_Taken = 1'b0;
    bus.Jump         = 1'b0;
    bus.Jalr         = 1'b0;
    bus.PC_Imm       = 32'h0;
    bus.JALR_Target  = 32'h0;

    // Reset values while RSTN is low, then first fetch on the 2nd cycle.
    #2;
    check_reset("reset");
    step();
    step();
    RSTN = 1'b1;
    @(negedge CLK);
    check("req_cycle1", {31'h0, bus.IMem_Req}, 32'h0);
    exp_fetch(32'h0, 1'b0);
    @(negedge CLK);
    check("req_cycle2",  {31'h0, bus.IMem_Req}, 32'h1);
    check("addr_cycle2", bus.IMem_Addr, 32'h0);

    // Sequential run: four plain retires.
    exp_fetch(32'h4,  1'b1);
    exp_fetch(32'h8,  1'b1);
    exp_fetch(32'hC,  1'b1);
    exp_fetch(32'h10, 1'b1);
    repeat (4) do_retire(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    check("seq_instret", bus.Instret, 32'd4);
    check("seq_pc",      bus.PC,      32'h10);

    // Branch and JALR together: JALR wins with bit 0 cleared.
    exp_fetch(32'h80, 1'b1);
    do_retire(1'b1, 1'b0, 1'b1, 32'h40, 32'h81);
    check("jalr_pc",      bus.PC,      32'h80);
    check("jalr_instret", bus.Instret, 32'd5);

    // Aligned jump back to 0x10.
    exp_fetch(32'h10, 1'b1);
    do_retire(1'b0, 1'b1, 1'b0, 32'h10, 32'h0);
    check("jump_pc", bus.PC, 32'h10);

    // Misaligned jump: trap to 0x100, Instret unchanged.
    trap_q.push_back('{32'h100, 32'h10, 32'h22, 32'd6});
    exp_fetch(32'h100, 1'b1);
    do_retire(1'b0, 1'b1, 1'b0, 32'h22, 32'h0);
    check("trap_pulse",       {31'h0, bus.Trap}, 32'h1);
    check("trap_instret_now", bus.Instret, 32'd6);
    step();
    check("trap_width",     {31'h0, bus.Trap}, 32'h0);
    check("trap_pc_held",   bus.Trap_PC,   32'h10);
    check("trap_tval_held", bus.Trap_Tval, 32'h22);

    // Aligned taken branch.
    exp_fetch(32'h200, 1'b0);
    do_retire(1'b1, 1'b0, 1'b0, 32'h200, 32'h0);
    check("branch_pc",      bus.PC,      32'h200);
    check("branch_instret", bus.Instret, 32'd7);

    // Delayed acknowledge with Hold raised mid-FETCH.
    wait_valid();
    bus.IMem_Ack = 1'b0;
    exp_fetch(32'h204, 1'b0);
    do_retire(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    bus.Hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      check("stall_req",  {31'h0, bus.IMem_Req}, 32'h1);
      check("stall_addr", bus.IMem_Addr, 32'h204);
    end
    step();
    bus.IMem_Ack = 1'b1;
    do_retire(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      check("idle_req",   {31'h0, bus.IMem_Req},    32'h0);
      check("idle_valid", {31'h0, bus.Instr_Valid}, 32'h0);
    end
    check("idle_pc",      bus.PC,      32'h208);
    check("idle_instret", bus.Instret, 32'd9);
    step();
    bus.Hold = 1'b0;
    exp_fetch(32'h208, 1'b0);

    // Instret wraps from all-ones to zero on a normal retire.
    wait_valid();
    force dut.instret_q = 32'hFFFF_FFFF;
    #1;
    release dut.instret_q;
    exp_fetch(32'h20C, 1'b0);
    do_retire(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    check("wrap_instret", bus.Instret, 32'h0);
    check("wrap_pc",      bus.PC,      32'h20C);

    // Reset mid-EXEC with Instret at all-ones: everything back to reset values.
    wait_valid();
    force dut.instret_q = 32'hFFFF_FFFF;
    #1;
    release dut.instret_q;
    RSTN = 1'b0;
    #1;
    check_reset("midexec");
    step();
    step();

    check("fetch_queue_left", 32'(fetch_q.size()), 32'd0);
    check("trap_queue_left",  32'(trap_q.size()),  32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
